// File: rtl/cgra_config_loader_if.sv
// Handshake bundle between the CGRA config loader, its bitstream configurator and the array.
// The master modport is the loader's view; slave is the surrounding system's view.
interface cgra_config_loader_if;
  logic        start;
  logic        cfg_sync_reset;
  logic        cfg_enable;
  logic        cfg_bitstream;
  logic        cfg_done;
  logic        chain_bitstream;
  logic        chain_enable;
  logic        cgra_reset;
  logic        expected_parity;
  logic        busy;
  logic        loaded;
  logic        error;
  logic [31:0] bit_count;

  modport master (
    input  start, cfg_bitstream, cfg_done, expected_parity,
    output cfg_sync_reset, cfg_enable, chain_bitstream, chain_enable,
           cgra_reset, busy, loaded, error, bit_count
  );

  modport slave (
    output start, cfg_bitstream, cfg_done, expected_parity,
    input  cfg_sync_reset, cfg_enable, chain_bitstream, chain_enable,
           cgra_reset, busy, loaded, error, bit_count
  );
endinterface

// File: rtl/cgra_config_loader.sv
// Resets a bitstream configurator, streams NUM_BITS bits into the CGRA config chain, then releases the array.
// Optional chain parity check: define CGRA_CONFIG_LOADER_PARITY_EN.
module cgra_config_loader #(
  parameter int NUM_BITS      = 772,
  parameter int SETTLE_CYCLES = 4,
  parameter int DONE_TIMEOUT  = 8
) (
  input  logic                  clock,
  input  logic                  sync_reset,
  cgra_config_loader_if.master  bus
);

  typedef enum logic [2:0] {IDLE, CFG_RST, SHIFT, DRAIN, SETTLE, RUN} state_e;

  localparam logic [31:0] SHIFT_LAST  = 32'(NUM_BITS - 1);
  localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 32'd0 : 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST  = (DONE_TIMEOUT == 0)  ? 32'd0 : 32'(DONE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] bit_count_q;
  logic        cfg_srst_q, cfg_en_q;
  logic        en_d1_q, chain_en_q, chain_bit_q;
  logic        error_q, error_d;
  logic        pulse_seen_q, pulse_seen_d;
  logic        done_seen_q, done_seen_d;
  logic        start_accept, last_pulse, parity_ok;
  logic        pulse_ok, done_ok;

`ifdef CGRA_CONFIG_LOADER_PARITY_EN
  logic parity_q;
  // Fold in a bit still on the chain this cycle so the decision never lags the last pulse.
  assign parity_ok = ((parity_q ^ (chain_en_q & chain_bit_q)) == bus.expected_parity);
`else
  assign parity_ok = 1'b1;
`endif

  assign start_accept = bus.start && ((state_q == IDLE) || (state_q == RUN));
  assign last_pulse   = chain_en_q && !en_d1_q;
  assign pulse_ok     = pulse_seen_q || last_pulse;
  assign done_ok      = done_seen_q || bus.cfg_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    error_d      = error_q;
    pulse_seen_d = pulse_seen_q;
    done_seen_d  = done_seen_q;

    unique case (state_q)
      IDLE, RUN: begin
        if (start_accept) begin
          state_d = CFG_RST;
          error_d = 1'b0;
        end
      end
      CFG_RST: begin
        state_d      = SHIFT;
        pulse_seen_d = 1'b0;
        done_seen_d  = 1'b0;
      end
      SHIFT: begin
        // A done during shifting means the configurator holds fewer bits than the chain.
        if (bus.cfg_done) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (cnt_q == SHIFT_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        pulse_seen_d = pulse_ok;
        done_seen_d  = done_ok;
        if (pulse_ok && done_ok) begin
          if (parity_ok) begin
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (sync_reset) begin
      state_d = IDLE;
      error_d = 1'b0;
    end

    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (sync_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cfg_srst_q   <= 1'b1;
      cfg_en_q     <= 1'b0;
      en_d1_q      <= 1'b0;
      chain_en_q   <= 1'b0;
      chain_bit_q  <= 1'b0;
      error_q      <= 1'b0;
      bit_count_q  <= '0;
      pulse_seen_q <= 1'b0;
      done_seen_q  <= 1'b0;
`ifdef CGRA_CONFIG_LOADER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      pulse_seen_q <= pulse_seen_d;
      done_seen_q  <= done_seen_d;
      cfg_srst_q   <= (state_d == CFG_RST);
      cfg_en_q     <= (state_d == SHIFT);
      if (start_accept) begin
        en_d1_q     <= 1'b0;
        chain_en_q  <= 1'b0;
        chain_bit_q <= 1'b0;
        bit_count_q <= '0;
`ifdef CGRA_CONFIG_LOADER_PARITY_EN
        parity_q    <= 1'b0;
`endif
      end else begin
        // Configurator bit appears the cycle after its enable; it reaches the chain one cycle later.
        en_d1_q     <= cfg_en_q;
        chain_en_q  <= en_d1_q;
        chain_bit_q <= en_d1_q & bus.cfg_bitstream;
        if (chain_en_q && (bit_count_q != 32'hFFFF_FFFF)) bit_count_q <= bit_count_q + 32'd1;
`ifdef CGRA_CONFIG_LOADER_PARITY_EN
        parity_q    <= parity_q ^ (chain_en_q & chain_bit_q);
`endif
      end
    end
  end

  assign bus.cfg_sync_reset  = cfg_srst_q;
  assign bus.cfg_enable      = cfg_en_q;
  assign bus.chain_enable    = chain_en_q;
  assign bus.chain_bitstream = chain_bit_q;
  assign bus.cgra_reset      = (state_q != RUN);
  assign bus.busy            = (state_q != IDLE) && (state_q != RUN);
  assign bus.loaded          = (state_q == RUN);
  assign bus.error           = error_q;
  assign bus.bit_count       = bit_count_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader with an 8-bit chain and a behavioural serial configurator.
// Parity-specific steps follow CGRA_CONFIG_LOADER_PARITY_EN when the bench is built with it.
module tb_cgra_config_loader;
  logic clock;
  logic sync_reset;
  cgra_config_loader_if bus ();

  cgra_config_loader #(.NUM_BITS(8), .SETTLE_CYCLES(4), .DONE_TIMEOUT(8)) dut (
    .clock      (clock),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Configurator model: reset by cfg_sync_reset, emits cfg_len bits MSB-first, then raises done.
  logic [7:0] pat;
  int         cfg_len;
  logic       done_tie0;
  int         cfg_cnt;
  logic       cfg_bit, cfg_done_r;

  always @(posedge clock) begin
    if (bus.cfg_sync_reset) begin
      cfg_cnt    <= 0;
      cfg_bit    <= 1'b0;
      cfg_done_r <= 1'b0;
    end else if (bus.cfg_enable) begin
      cfg_bit <= (cfg_cnt < cfg_len) ? pat[cfg_len - 1 - cfg_cnt] : 1'b0;
      cfg_cnt <= cfg_cnt + 1;
      if (cfg_cnt == cfg_len - 1) cfg_done_r <= 1'b1;
    end
  end

  assign bus.cfg_bitstream = cfg_bit;
  assign bus.cfg_done      = cfg_done_r & ~done_tie0;

  // Chain monitor: counts pulses and keeps the last 8 bits shifted in.
  int         mon_pulses = 0;
  logic [7:0] mon_word   = '0;
  always @(posedge clock) begin
    if (bus.chain_enable) begin
      mon_pulses <= mon_pulses + 1;
      mon_word   <= {mon_word[6:0], bus.chain_bitstream};
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_not_busy(input int max_cycles, input string tag);
    int n = 0;
    while (bus.busy && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  int base;

  initial begin
    sync_reset          = 1'b1;
    bus.start           = 1'b0;
    bus.expected_parity = 1'b0;
    pat                 = 8'b1011_0010;
    cfg_len             = 8;
    done_tie0           = 1'b0;
    step();
    step();

    // Reset state
    check("rst_cfg_sync_reset", bus.cfg_sync_reset, 1);
    check("rst_cfg_enable", bus.cfg_enable, 0);
    check("rst_chain_enable", bus.chain_enable, 0);
    check("rst_cgra_reset", bus.cgra_reset, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_loaded", bus.loaded, 0);
    check("rst_error", bus.error, 0);
    check("rst_bit_count", bus.bit_count, 0);
    sync_reset = 1'b0;
    step();
    check("idle_cfg_sync_reset", bus.cfg_sync_reset, 0);

    // Normal load, cycle by cycle
    pulse_start();
    check("cfgrst_pulse", bus.cfg_sync_reset, 1);
    check("cfgrst_no_enable", bus.cfg_enable, 0);
    check("cfgrst_busy", bus.busy, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("load_cfg_enable_%0d", k), bus.cfg_enable, (k < 8) ? 1 : 0);
      check($sformatf("load_cfg_srst_%0d", k), bus.cfg_sync_reset, 0);
      check($sformatf("load_chain_en_%0d", k), bus.chain_enable, (k >= 2) ? 1 : 0);
      check($sformatf("load_chain_bit_%0d", k), bus.chain_bitstream, (k >= 2) ? {31'd0, pat[9 - k]} : 0);
    end
    step();
    check("settle_bit_count", bus.bit_count, 8);
    check("settle_cgra_reset", bus.cgra_reset, 1);
    check("settle_busy", bus.busy, 1);
    repeat (3) step();
    check("settle_end_loaded", bus.loaded, 0);
    step();
    check("run_loaded", bus.loaded, 1);
    check("run_cgra_reset", bus.cgra_reset, 0);
    check("run_busy", bus.busy, 0);
    check("run_error", bus.error, 0);
    check("run_chain_word", mon_word, 8'hB2);

    // Reload from RUN; a start during SHIFT is ignored
    base = mon_pulses;
    pulse_start();
    check("reload_loaded_drop", bus.loaded, 0);
    check("reload_bit_count_clr", bus.bit_count, 0);
    check("reload_cgra_reset", bus.cgra_reset, 1);
    repeat (3) step();
    pulse_start();
    wait_not_busy(40, "reload_timeout");
    check("reload_loaded", bus.loaded, 1);
    check("reload_pulses", mon_pulses - base, 8);
    check("reload_bit_count", bus.bit_count, 8);

    // Short configurator: done rises during SHIFT
    cfg_len = 6;
    pulse_start();
    repeat (7) step();
    check("short_busy_before", bus.busy, 1);
    check("short_error_before", bus.error, 0);
    step();
    check("short_error", bus.error, 1);
    check("short_idle", bus.busy, 0);
    check("short_cgra_reset", bus.cgra_reset, 1);
    check("short_loaded", bus.loaded, 0);
    cfg_len = 8;

    // cfg_done never arrives: DRAIN times out
    done_tie0 = 1'b1;
    pulse_start();
    check("to_start_clears_error", bus.error, 0);
    repeat (16) step();
    check("to_drain_busy", bus.busy, 1);
    check("to_drain_no_error", bus.error, 0);
    step();
    check("to_error", bus.error, 1);
    check("to_loaded", bus.loaded, 0);
    check("to_cgra_reset", bus.cgra_reset, 1);
    check("to_bit_count", bus.bit_count, 8);
    done_tie0 = 1'b0;

    // sync_reset on the 4th SHIFT cycle
    pulse_start();
    check("sr_start_clears_error", bus.error, 0);
    base = mon_pulses;
    repeat (4) step();
    check("sr_shifting", bus.cfg_enable, 1);
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    check("sr_cfg_sync_reset", bus.cfg_sync_reset, 1);
    check("sr_cfg_enable", bus.cfg_enable, 0);
    check("sr_chain_enable", bus.chain_enable, 0);
    check("sr_chain_bit", bus.chain_bitstream, 0);
    check("sr_cgra_reset", bus.cgra_reset, 1);
    check("sr_busy", bus.busy, 0);
    check("sr_loaded", bus.loaded, 0);
    check("sr_error", bus.error, 0);
    check("sr_bit_count", bus.bit_count, 0);
    repeat (6) step();
    check("sr_no_more_pulses", mon_pulses - base, 2);
    check("sr_idle_enable", bus.cfg_enable, 0);
    pulse_start();
    wait_not_busy(40, "sr_reload_timeout");
    check("sr_reload_loaded", bus.loaded, 1);
    check("sr_reload_bit_count", bus.bit_count, 8);
    check("sr_reload_word", mon_word, 8'hB2);

    // Parity: 8'b1011_0010 has even parity
    bus.expected_parity = 1'b1;
    pulse_start();
    wait_not_busy(40, "par1_timeout");
`ifdef CGRA_CONFIG_LOADER_PARITY_EN
    check("par1_error", bus.error, 1);
    check("par1_loaded", bus.loaded, 0);
    bus.expected_parity = 1'b0;
    pulse_start();
    wait_not_busy(40, "par0_timeout");
    check("par0_loaded", bus.loaded, 1);
    check("par0_error", bus.error, 0);
`else
    check("par_ignored_loaded", bus.loaded, 1);
    check("par_ignored_error", bus.error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
